// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter that shares one rom_ctrl among NUM_REQ requesters
// Ports:
//   clk, rst (async, active high)
//   req[NUM_REQ], req_idx[NUM_REQ*IDX_W]  : per-requester read request and binary entry index
//   ack[NUM_REQ], rsp_data[DW]            : one-cycle ack pulse to the served requester, read data
//   busy                                  : FSM not idle
//   rom_en, rom_addr[2**IDX_W], rom_data  : rom_ctrl interface (one-hot address, registered data)
//   rd_cnt[16]                            : completed-read counter, present only with ROM_ARB_STATS_EN
module rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3,
  parameter int DW      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       ack,
  output logic [DW-1:0]            rsp_data,
  output logic                     busy,
  output logic                     rom_en,
  output logic [(2**IDX_W)-1:0]    rom_addr,
  input  logic [DW-1:0]            rom_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [15:0]              rd_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int AW = 2**IDX_W;
  typedef enum logic [1:0] {IDLE, READ, CAPT, DONE} state_t;
  state_t state;
  logic [PW-1:0] ptr, gnt, win;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_arr [NUM_REQ];
  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_idx
    assign idx_arr[g] = req_idx[g*IDX_W +: IDX_W];
  end
  // Scan downward so the last hit is the first set request at or after ptr.
  always_comb begin
    win = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[PW'((int'(ptr) + k) % NUM_REQ)]) win = PW'((int'(ptr) + k) % NUM_REQ);
  end
  assign rom_en   = state == READ;
  assign rom_addr = rom_en ? AW'(1) << idx : '0;
  assign busy     = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      idx      <= '0;
      ack      <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          gnt   <= win;
          idx   <= idx_arr[win];
          state <= READ;
        end
        READ: state <= CAPT;
        CAPT: begin
          rsp_data <= rom_data;
          ack[gnt] <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          ack   <= '0;
          ptr   <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ROM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_cnt <= '0;
    else if (state == CAPT && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
  end
`endif
endmodule
